// File: rtl/sa_out_drain.sv
// Drains one SA_SIZE x SA_SIZE tile from the deskew buffer, saturating each word; one word per cycle, one shift per row.
// Output register refills only when empty or accepted, so m_ready low freezes data, counters and the FSM.
module sa_out_drain #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 32,
  parameter int OUT_SIZE        = 16,
  localparam int IDX_W          = $clog2(SA_SIZE)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [ACTIVATION_SIZE-1:0] fifo_data,
  output logic [IDX_W-1:0]           fifo_idx,
  output logic                       shift_req,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUT_SIZE-1:0]        m_data,
  output logic                       m_last,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_SIZE - 1);

  state_t             state;
  logic [IDX_W-1:0]   col_cnt;
  logic [IDX_W-1:0]   row_cnt;
  logic [OUT_SIZE-1:0] sat_data;
  logic               load;
  logic               hs;

  // In range iff every bit from the output sign bit upward matches.
  generate
    if (OUT_SIZE == ACTIVATION_SIZE) begin : g_pass
      assign sat_data = fifo_data;
    end else begin : g_sat
      logic [ACTIVATION_SIZE-OUT_SIZE:0] top;
      assign top = fifo_data[ACTIVATION_SIZE-1:OUT_SIZE-1];
      always_comb begin
        sat_data = fifo_data[OUT_SIZE-1:0];
        if (!((&top) || !(|top))) begin
          sat_data = fifo_data[ACTIVATION_SIZE-1] ? {1'b1, {(OUT_SIZE-1){1'b0}}}
                                                  : {1'b0, {(OUT_SIZE-1){1'b1}}};
        end
      end
    end
  endgenerate

  assign load      = (state == S_READ) && (!m_valid || m_ready);
  assign hs        = m_valid && m_ready;
  assign fifo_idx  = col_cnt;
  assign shift_req = (state == S_SHIFT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        col_cnt <= '0;
        row_cnt <= '0;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            col_cnt <= '0;
            row_cnt <= '0;
            if (start) state <= S_READ;
          end
          S_READ: begin
            if (load) begin
              m_data  <= sat_data;
              m_valid <= 1'b1;
              m_last  <= (row_cnt == LAST_IDX) && (col_cnt == LAST_IDX);
              if (col_cnt == LAST_IDX) begin
                col_cnt <= '0;
                state   <= (row_cnt == LAST_IDX) ? S_DONE : S_SHIFT;
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end
            end
          end
          S_SHIFT: begin
            // The buffer shifts this cycle, so no word is sampled; a pending word may still drain.
            row_cnt <= row_cnt + 1'b1;
            state   <= S_READ;
            if (hs) m_valid <= 1'b0;
          end
          S_DONE: begin
            if (hs) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              done    <= 1'b1;
              state   <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sa_out_drain.sv
// Directed bench for sa_out_drain (SA_SIZE=4) with a buffer model and an expected-word scoreboard.
module tb_sa_out_drain;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [31:0] fifo_data;
  logic [1:0]  fifo_idx;
  logic        shift_req;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  sa_out_drain #(.SA_SIZE(4), .ACTIVATION_SIZE(32), .OUT_SIZE(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .fifo_data(fifo_data), .fifo_idx(fifo_idx), .shift_req(shift_req),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: row advances on every shift, restarts when a tile is accepted.
  logic [31:0] tbl [16];
  logic [15:0] exp_tbl [16];
  logic [1:0]  brow;
  always @(posedge clk) begin
    if (start && !busy && !abort) brow <= 2'd0;
    else if (shift_req) brow <= brow + 2'd1;
  end
  assign fifo_data = tbl[{brow, fifo_idx}];

  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          n_hs, n_done, last_cycle, done_cycle;
  int          shift_cycles[$];
  logic [16:0] exp_q[$];
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    if (s > 32'sd32767) return 16'h7fff;
    else if (s < -32'sd32768) return 16'h8000;
    else return v[15:0];
  endfunction

  // One cycle: drive m_ready, observe outputs of this cycle, advance to the next.
  task automatic step(input logic rdy);
    logic [16:0] e;
    m_ready = rdy;
    if (prev_stall) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(prev_data));
      chk("stall_last", 32'(m_last), 32'(prev_last));
    end
    if (shift_req) shift_cycles.push_back(cyc);
    if (done) begin
      n_done++;
      done_cycle = cyc;
    end
    if (m_valid && m_ready) begin
      n_hs++;
      if (m_last) last_cycle = cyc;
      ncmp++;
      assert (exp_q.size() != 0) else begin
        nfail++;
        $error("FAIL sb_extra: observed word %0h expected none", m_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(m_data), 32'(e[15:0]));
        chk("sb_last", 32'(m_last), 32'(e[16]));
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic begin_tile();
    n_hs = 0;
    n_done = 0;
    last_cycle = -1;
    done_cycle = -1;
    prev_stall = 1'b0;
    shift_cycles.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), exp_tbl[i]});
    cyc = 0;
    start = 1'b1;
  endtask

  // mode 0: m_ready high; mode 1: m_ready toggles 1,0. noise_at >= 0 pulses start while busy.
  task automatic run(input int mode, input int budget, input int noise_at);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      if (k == noise_at && k > 0) start = 1'b1;
      step((mode == 0) ? 1'b1 : (k % 2 == 0));
      k++;
    end
    chk("done_seen", 32'(n_done), 32'd1);
    step(1'b1);
    step(1'b1);
    chk("done_width", 32'(n_done), 32'd1);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic check_nominal(input string t);
    chk({t, "_words"}, 32'(n_hs), 32'd16);
    chk({t, "_last_cyc"}, 32'(last_cycle), 32'd20);
    chk({t, "_done_cyc"}, 32'(done_cycle), 32'd21);
    chk({t, "_shift_n"}, 32'(shift_cycles.size()), 32'd3);
    chk({t, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin
      tbl[i]     = 32'(16 * (i / 4) + (i % 4));
      exp_tbl[i] = 16'(16 * (i / 4) + (i % 4));
    end
  endtask

  initial begin
    int sexp [3];
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    m_ready = 1'b0;
    brow = 2'd0;
    prev_stall = 1'b0;
    load_ramp();
    #3;
    chk("rst_idx", 32'(fifo_idx), 32'd0);
    chk("rst_shift", 32'(shift_req), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Nominal drain, m_ready held high.
    begin_tile();
    run(0, 60, -1);
    check_nominal("t1");
    sexp[0] = 5; sexp[1] = 10; sexp[2] = 15;
    for (int i = 0; i < 3; i++)
      chk("t1_shift_cyc", (i < shift_cycles.size()) ? 32'(shift_cycles[i]) : 32'hffff_ffff, 32'(sexp[i]));

    // Backpressure: m_ready toggles every cycle.
    begin_tile();
    run(1, 120, -1);
    chk("t2_words", 32'(n_hs), 32'd16);
    chk("t2_shift_n", 32'(shift_cycles.size()), 32'd3);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Saturation corners plus a few extra values through the same path.
    tbl[0] = 32'h0001_0000; exp_tbl[0] = 16'h7fff;
    tbl[1] = 32'hffff_0000; exp_tbl[1] = 16'h8000;
    tbl[2] = 32'hffff_fffe; exp_tbl[2] = 16'hfffe;
    tbl[3] = 32'h0000_1234; exp_tbl[3] = 16'h1234;
    tbl[4] = 32'h0000_7fff; tbl[5] = 32'hffff_8000;
    tbl[6] = 32'h8000_0000; tbl[7] = 32'h7fff_ffff;
    tbl[8] = 32'h0000_8000; tbl[9] = 32'hffff_7fff;
    for (int i = 10; i < 16; i++) tbl[i] = $urandom();
    for (int i = 4; i < 16; i++) exp_tbl[i] = sat16(tbl[i]);
    begin_tile();
    run(0, 60, -1);
    check_nominal("t3");

    // Abort in the cycle after the second shift.
    load_ramp();
    begin_tile();
    while (cyc < 11) step(1'b1);
    chk("t4_shifts_before", 32'(shift_cycles.size()), 32'd2);
    abort = 1'b1;
    step(1'b1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(m_valid), 32'd0);
    chk("t4_last", 32'(m_last), 32'd0);
    chk("t4_shift", 32'(shift_req), 32'd0);
    chk("t4_idx", 32'(fifo_idx), 32'd0);
    exp_q.delete();
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("t4_no_done", 32'(n_done), 32'd0);
    begin_tile();
    run(0, 60, -1);
    check_nominal("t4r");

    // Asynchronous reset mid-READ with a word pending.
    begin_tile();
    while (cyc < 4) step(1'b0);
    chk("t5_valid_before", 32'(m_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_idx", 32'(fifo_idx), 32'd0);
    chk("t5_shift", 32'(shift_req), 32'd0);
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_data", 32'(m_data), 32'd0);
    chk("t5_last", 32'(m_last), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    #1 resetn = 1'b1;
    @(negedge clk);
    exp_q.delete();
    begin_tile();
    run(0, 60, 7);
    check_nominal("t5r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
